modport_reg: RTL and testbench

//   Parameterised enable-gated data register: the block under test behind the

---
 rtl/modport_reg.sv | 45 ++++
 tb/tb_modport_reg.sv | 138 +++++++++++++
 2 files changed

// File: rtl/modport_reg.sv
// Enable-gated data register with synchronous active-low reset.
// outa is driven only by the storage flops; reset takes priority over enable.
module modport_reg #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] outa
);

  logic [WIDTH-1:0] outa_d;
  logic [WIDTH-1:0] outa_q;

  always_comb begin
    outa_d = outa_q;
    if (!reset_n) begin
      outa_d = RESET_VALUE;
    end else if (enable) begin
      outa_d = data;
    end
  end

  always_ff @(posedge clk) begin
    outa_q <= outa_d;
  end

  assign outa = outa_q;

`ifndef SYNTHESIS
  // Control inputs must be known at every edge where they steer the update.
  a_reset_n_known : assert property (@(posedge clk) !$isunknown(reset_n))
    else $error("reset_n is X/Z at a clock edge");
  a_enable_known : assert property (@(posedge clk) reset_n |-> !$isunknown(enable))
    else $error("enable is X/Z at a non-reset edge");

  a_reset_loads : assert property (@(posedge clk) !reset_n |=> (outa == RESET_VALUE))
    else $error("outa did not take RESET_VALUE after a reset edge");
  a_hold_stable : assert property (@(posedge clk) (!enable && reset_n) |=> $stable(outa))
    else $error("outa changed across a non-enabled edge");
`endif

endmodule

// File: tb/tb_modport_reg.sv
// Directed-vector and random checking of modport_reg at WIDTH=8 (default reset)
// and WIDTH=16 with RESET_VALUE=16'hBEEF, both driven from the same controls.
module tb_modport_reg;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] data16;
  logic [7:0]  outa8;
  logic [15:0] outa16;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m8;
  logic [15:0] m16;

  modport_reg #(
    .WIDTH (8)
  ) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .data    (data16[7:0]),
    .outa    (outa8)
  );

  modport_reg #(
    .WIDTH       (16),
    .RESET_VALUE (16'hBEEF)
  ) u_dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .data    (data16),
    .outa    (outa16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic [7:0] exp8;
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one edge worth of inputs, sample 1 ns after the edge, advance models.
  task automatic cycle(input logic rn, input logic en, input logic [15:0] d);
    reset_n = rn;
    enable  = en;
    data16  = d;
    @(posedge clk);
    #1;
    if (!rn) begin
      m8  = 8'h00;
      m16 = 16'hBEEF;
    end else if (en) begin
      m8  = d[7:0];
      m16 = d;
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    data16  = '0;
    m8      = '0;
    m16     = '0;

    vecs.push_back('{1'b0, 1'b1, 8'hA5, 8'h00, "rst_edge1"});
    vecs.push_back('{1'b0, 1'b1, 8'hA5, 8'h00, "rst_edge2"});
    vecs.push_back('{1'b1, 1'b1, 8'h3C, 8'h3C, "write_3c"});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h3C, "hold_ff"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h3C, "hold_00"});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h3C, "hold_ff2"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h3C, "hold_002"});
    vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h01, "stream_01"});
    vecs.push_back('{1'b1, 1'b1, 8'h02, 8'h02, "stream_02"});
    vecs.push_back('{1'b1, 1'b1, 8'h03, 8'h03, "stream_03"});
    vecs.push_back('{1'b0, 1'b1, 8'h77, 8'h00, "rst_drops_77"});
    vecs.push_back('{1'b1, 1'b1, 8'h77, 8'h77, "resume_77"});
    vecs.push_back('{1'b1, 1'b0, 8'h12, 8'h77, "hold_after_resume"});
    vecs.push_back('{1'b0, 1'b0, 8'h12, 8'h00, "rst_no_enable"});
    vecs.push_back('{1'b1, 1'b0, 8'h55, 8'h00, "hold_reset_value"});
    vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h80, "write_msb"});

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].en, {vecs[i].data ^ 8'h5A, vecs[i].data});
      chk(vecs[i].name, {8'h00, outa8}, {8'h00, vecs[i].exp8});
      chk({vecs[i].name, "_w16"}, outa16, m16);
    end

    // Wide reset value and full-width capture on the 16-bit instance.
    cycle(1'b0, 1'b1, 16'h1234);
    chk("w16_reset_beef", outa16, 16'hBEEF);
    cycle(1'b1, 1'b1, 16'hFFFF);
    chk("w16_all_ones", outa16, 16'hFFFF);
    chk("w8_all_ones", {8'h00, outa8}, 16'h00FF);
    cycle(1'b1, 1'b1, 16'h8001);
    chk("w16_edge_bits", outa16, 16'h8001);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("w16_hold", outa16, 16'h8001);
    cycle(1'b0, 1'b0, 16'h0000);
    chk("w16_reset_again", outa16, 16'hBEEF);

    // Random enable/data with occasional resets against the bench model.
    for (int n = 0; n < 1000; n++) begin
      logic rn;
      logic en;
      logic [15:0] d;
      rn = ($urandom_range(0, 31) != 0);
      en = $urandom_range(0, 1) == 1;
      d  = 16'($urandom);
      cycle(rn, en, d);
      chk("rand_w8", {8'h00, outa8}, {8'h00, m8});
      chk("rand_w16", outa16, m16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
